// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-port round-robin arbiter and sequencer for the memory-mapped I/O bus
module io_bus_arbiter #(
    parameter int          HOLD_CYCLES = 1,
    parameter logic [31:0] SW_ADDR     = 32'hFFFF_FFF0,
    parameter logic [31:0] SEG_ADDR    = 32'hFFFF_FFF8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    input  logic        req0_we,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    input  logic        req1_we,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic        req1_err,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    output logic        io_we,
    output logic        io_mreq,
    input  logic [31:0] io_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES);

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        grant_q;
    logic        err_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  hold_cnt;

    logic        pick;
    logic        accept;
    logic [31:0] sel_addr;
    logic        mapped;
    logic        hold_last;

    // Arbitration: a lone requester wins; on contention the port not granted last time wins.
    // Accept is suppressed while rst is high so a requester never sees ready for a dropped request.
    always_comb begin
        pick      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        accept    = (state == IDLE) && (req0_valid || req1_valid) && !rst;
        sel_addr  = pick ? req1_addr : req0_addr;
        mapped    = (sel_addr == SW_ADDR) || (sel_addr == SEG_ADDR);
        hold_last = (hold_cnt == HOLD_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: unmapped addresses skip the bus entirely and go straight to DONE
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = mapped ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (hold_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transaction registers: latch the granted request on accept, count hold cycles, capture read data
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            hold_cnt   <= 4'd0;
        end else if (accept) begin
            last_grant <= pick;
            grant_q    <= pick;
            err_q      <= !mapped;
            we_q       <= pick ? req1_we : req0_we;
            addr_q     <= sel_addr;
            wdata_q    <= pick ? req1_wdata : req0_wdata;
            hold_cnt   <= mapped ? 4'd1 : 4'd0;
        end else if (state == ISSUE) begin
            if (hold_last) begin
                rdata_q  <= io_rdata;
                hold_cnt <= 4'd0;
            end else begin
                hold_cnt <= hold_cnt + 4'd1;
            end
        end
    end

    // Output decode: bus driven only in ISSUE, responses only in DONE and only to the granted port
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        req0_done  = 1'b0;
        req1_done  = 1'b0;
        req0_err   = 1'b0;
        req1_err   = 1'b0;
        req0_rdata = 32'd0;
        req1_rdata = 32'd0;
        io_addr    = 32'd0;
        io_wdata   = 32'd0;
        io_we      = 1'b0;
        io_mreq    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    req0_ready = ~pick;
                    req1_ready = pick;
                end
            end
            ISSUE: begin
                io_addr  = addr_q;
                io_wdata = wdata_q;
                io_we    = we_q;
                io_mreq  = 1'b1;
            end
            DONE: begin
                if (grant_q) begin
                    req1_done  = 1'b1;
                    req1_err   = err_q;
                    req1_rdata = err_q ? 32'd0 : rdata_q;
                end else begin
                    req0_done  = 1'b1;
                    req0_err   = err_q;
                    req0_rdata = err_q ? 32'd0 : rdata_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - table-driven and sequence checks for io_bus_arbiter
module tb_io_bus_arbiter;

    localparam logic [31:0] SA = 32'hFFFF_FFF0;
    localparam logic [31:0] GA = 32'hFFFF_FFF8;
    localparam logic [31:0] UA = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, we0, v1, we1;
    logic [31:0] a0, wd0, a1, wd1, iord;

    logic        r0, r1, d0, d1, e0, e1, mreq, iowe;
    logic [31:0] rd0, rd1, ioa, iowd;
    logic        h_r0, h_r1, h_d0, h_d1, h_e0, h_e1, h_mreq, h_iowe;
    logic [31:0] h_rd0, h_rd1, h_ioa, h_iowd;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [31:0] a0;
        logic        we0;
        logic [31:0] wd0;
        logic        v1;
        logic [31:0] a1;
        logic        we1;
        logic [31:0] wd1;
        logic [31:0] iord;
        logic [1:0]  rdy;
        logic [1:0]  dn;
        logic [1:0]  er;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        mreq;
        logic [31:0] ioa;
        logic        iowe;
        logic [31:0] iowd;
    } vec_t;

    vec_t vecs[24];

    always #5 clk = ~clk;

    io_bus_arbiter #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_addr(a0), .req0_we(we0), .req0_wdata(wd0),
        .req0_ready(r0), .req0_done(d0), .req0_rdata(rd0), .req0_err(e0),
        .req1_valid(v1), .req1_addr(a1), .req1_we(we1), .req1_wdata(wd1),
        .req1_ready(r1), .req1_done(d1), .req1_rdata(rd1), .req1_err(e1),
        .io_addr(ioa), .io_wdata(iowd), .io_we(iowe), .io_mreq(mreq), .io_rdata(iord)
    );

    io_bus_arbiter #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_addr(a0), .req0_we(we0), .req0_wdata(wd0),
        .req0_ready(h_r0), .req0_done(h_d0), .req0_rdata(h_rd0), .req0_err(h_e0),
        .req1_valid(v1), .req1_addr(a1), .req1_we(we1), .req1_wdata(wd1),
        .req1_ready(h_r1), .req1_done(h_d1), .req1_rdata(h_rd1), .req1_err(h_e1),
        .io_addr(h_ioa), .io_wdata(h_iowd), .io_we(h_iowe), .io_mreq(h_mreq), .io_rdata(iord)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        v0 = 1'b0; a0 = 32'd0; we0 = 1'b0; wd0 = 32'd0;
        v1 = 1'b0; a1 = 32'd0; we1 = 1'b0; wd1 = 32'd0;
        iord = 32'd0;
    endtask

    task automatic do_reset();
        nxt();
        rst = 1'b1;
        clear_inputs();
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        int n_mreq, n_d0, n_bad1;
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);

        // rst, v0, a0, we0, wd0, v1, a1, we1, wd1, iord, rdy, dn, er, rd0, rd1, mreq, ioa, iowe, iowd
        vecs[0]  = '{1, 1, SA, 0, 0, 0, 0, 0, 0, 'hA5, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, SA, 0, 0, 0, 0, 0, 0, 'hA5, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, SA, 0, 0, 0, 0, 0, 0, 'hA5, 2'b00, 2'b00, 2'b00, 0, 0, 1, SA, 0, 0};
        vecs[3]  = '{0, 0, SA, 0, 0, 0, 0, 0, 0, 'hA5, 2'b00, 2'b01, 2'b00, 'hA5, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 'h5A, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                vecs[5 + 3*k] = '{0, 1, GA, 1, 'h11, 1, GA, 0, 'h22, 'h5A, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0};
                vecs[6 + 3*k] = '{0, 1, GA, 1, 'h11, 1, GA, 0, 'h22, 'h5A, 2'b00, 2'b00, 2'b00, 0, 0, 1, GA, 1, 'h11};
                vecs[7 + 3*k] = '{0, 1, GA, 1, 'h11, 1, GA, 0, 'h22, 'h5A, 2'b00, 2'b01, 2'b00, 'h5A, 0, 0, 0, 0, 0};
            end else begin
                vecs[5 + 3*k] = '{0, 1, GA, 1, 'h11, 1, GA, 0, 'h22, 'h5A, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0};
                vecs[6 + 3*k] = '{0, 1, GA, 1, 'h11, 1, GA, 0, 'h22, 'h5A, 2'b00, 2'b00, 2'b00, 0, 0, 1, GA, 0, 'h22};
                vecs[7 + 3*k] = '{0, 1, GA, 1, 'h11, 1, GA, 0, 'h22, 'h5A, 2'b00, 2'b10, 2'b00, 0, 'h5A, 0, 0, 0, 0};
            end
        end
        vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 'h5A, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0};
        vecs[18] = '{0, 0, 0, 0, 0, 1, UA, 1, 'h12, 'h77, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0};
        vecs[19] = '{0, 0, 0, 0, 0, 0, UA, 1, 'h12, 'h77, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0};
        vecs[20] = '{0, 1, SA, 0, 0, 0, 0, 0, 0, 'h33, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0};
        vecs[21] = '{0, 0, SA, 0, 0, 0, 0, 0, 0, 'h33, 2'b00, 2'b00, 2'b00, 0, 0, 1, SA, 0, 0};
        vecs[22] = '{0, 0, SA, 0, 0, 0, 0, 0, 0, 'h33, 2'b00, 2'b01, 2'b00, 'h33, 0, 0, 0, 0, 0};
        vecs[23] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 'h33, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 24; i++) begin
            nxt();
            rst = vecs[i].rst;
            v0 = vecs[i].v0; a0 = vecs[i].a0; we0 = vecs[i].we0; wd0 = vecs[i].wd0;
            v1 = vecs[i].v1; a1 = vecs[i].a1; we1 = vecs[i].we1; wd1 = vecs[i].wd1;
            iord = vecs[i].iord;
            settle();
            chk($sformatf("v%0d_ready", i), {30'd0, r1, r0}, {30'd0, vecs[i].rdy});
            chk($sformatf("v%0d_done", i), {30'd0, d1, d0}, {30'd0, vecs[i].dn});
            chk($sformatf("v%0d_err", i), {30'd0, e1, e0}, {30'd0, vecs[i].er});
            chk($sformatf("v%0d_rdata0", i), rd0, vecs[i].rd0);
            chk($sformatf("v%0d_rdata1", i), rd1, vecs[i].rd1);
            chk($sformatf("v%0d_mreq", i), {31'd0, mreq}, {31'd0, vecs[i].mreq});
            chk($sformatf("v%0d_io_addr", i), ioa, vecs[i].ioa);
            chk($sformatf("v%0d_io_we", i), {31'd0, iowe}, {31'd0, vecs[i].iowe});
            chk($sformatf("v%0d_io_wdata", i), iowd, vecs[i].iowd);
        end

        // Hold length of 3: bus fields stay constant while the requester changes its own fields
        do_reset();
        nxt();
        v0 = 1'b1; a0 = GA; we0 = 1'b1; wd0 = 32'h7B;
        settle();
        chk("hold_ready0", {31'd0, h_r0}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            nxt();
            v0 = 1'b0; a0 = SA; we0 = 1'b0; wd0 = 32'(i);
            settle();
            chk($sformatf("hold_mreq_t%0d", i), {31'd0, h_mreq}, 32'd1);
            chk($sformatf("hold_addr_t%0d", i), h_ioa, GA);
            chk($sformatf("hold_wdata_t%0d", i), h_iowd, 32'h7B);
            chk($sformatf("hold_we_t%0d", i), {31'd0, h_iowe}, 32'd1);
            chk($sformatf("hold_early_done_t%0d", i), {31'd0, h_d0}, 32'd0);
        end
        nxt();
        settle();
        chk("hold_done_t4", {31'd0, h_d0}, 32'd1);
        chk("hold_mreq_t4", {31'd0, h_mreq}, 32'd0);
        chk("hold_err_t4", {31'd0, h_e0}, 32'd0);
        nxt();
        settle();
        chk("hold_done_t5", {31'd0, h_d0}, 32'd0);

        // Reset during ISSUE, then contention must go to port 0 again
        do_reset();
        nxt();
        v0 = 1'b1; a0 = GA; we0 = 1'b0;
        settle();
        chk("rst_ready0", {31'd0, h_r0}, 32'd1);
        nxt();
        v0 = 1'b0; rst = 1'b1;
        settle();
        chk("rst_mreq_t1", {31'd0, h_mreq}, 32'd1);
        nxt();
        rst = 1'b0;
        settle();
        chk("rst_mreq_t2", {31'd0, h_mreq}, 32'd0);
        chk("rst_addr_t2", h_ioa, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_quiet_%0d", i),
                {26'd0, h_r0, h_r1, h_d0, h_d1, h_e0, h_mreq}, 32'd0);
            nxt();
            settle();
        end
        v0 = 1'b1; a0 = GA; v1 = 1'b1; a1 = SA; we1 = 1'b1; wd1 = 32'h99;
        settle();
        chk("rst_contention_ready", {30'd0, h_r1, h_r0}, 32'd1);

        // Port 1 withdraws while port 0 is in ISSUE
        nxt();
        v0 = 1'b0;
        settle();
        chk("wd_ready1", {31'd0, h_r1}, 32'd0);
        chk("wd_issue_addr", h_ioa, GA);
        nxt();
        v1 = 1'b0;
        n_mreq = 0; n_d0 = 0; n_bad1 = 0;
        for (int i = 0; i < 6; i++) begin
            settle();
            if (h_mreq) n_mreq++;
            if (h_d0) n_d0++;
            if (h_r1 || h_d1 || h_e1 || (h_rd1 != 32'd0) || (h_mreq && h_ioa == SA)) n_bad1++;
            nxt();
        end
        chk("wd_mreq_cycles", 32'(n_mreq), 32'd2);
        chk("wd_done0_count", 32'(n_d0), 32'd1);
        chk("wd_port1_activity", 32'(n_bad1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
